conv_operand_sequencer: RTL

Parametrised operand sequencer for the convolution PE. Snapshots an IN_N×IN_N input matrix and a K×K filter on `start`. Then streams one (input, filter) operand pair per cycle to the PE over a valid/ready handshake, walking every output window in row-major order and every filter tap in row-major order within each window. Supports stride and zero padding; out-of-bounds input taps read as zero. Replaces the fixed 4×4/3×3 mux-select operand input, so upstream control no longer drives per-cycle select bits.

---
 rtl/conv_operand_sequencer_pkg.sv | 16 +
 rtl/conv_operand_sequencer_if.sv | 21 ++
 rtl/conv_window_counter.sv | 77 +++++++
 rtl/conv_operand_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/conv_operand_sequencer_pkg.sv
// Shared types for the convolution operand sequencer: run-state encoding and
// the helper that sizes index counters.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Width of an index counting 0..n-1; a 1-entry range still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_operand_sequencer_if.sv
// Operand beat stream from the sequencer to the PE (valid/ready handshake).
interface conv_operand_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic              win_first;
  logic              win_last;

  modport master (
    output out_valid, a_out, b_out, win_first, win_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, a_out, b_out, win_first, win_last,
    output out_ready
  );
endinterface

// File: rtl/conv_window_counter.sv
// Four nested wrap counters (orow > ocol > kr > kc) walking every window and tap.
// The index outputs give the position the counters hold after the coming edge.
module conv_window_counter
  import conv_seq_pkg::*;
#(
  parameter int K     = 3,
  parameter int OUT_N = 2,
  localparam int KW   = idx_w(K),
  localparam int OW   = idx_w(OUT_N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [OW-1:0] orow_idx,
  output logic [OW-1:0] ocol_idx,
  output logic [KW-1:0] kr_idx,
  output logic [KW-1:0] kc_idx,
  output logic          first,
  output logic          last_tap,
  output logic          last_beat
);

  localparam logic [KW-1:0] K_MAX = KW'(K - 1);
  localparam logic [OW-1:0] O_MAX = OW'(OUT_N - 1);

  logic [OW-1:0] orow_reg, ocol_reg, orow_next, ocol_next;
  logic [KW-1:0] kr_reg, kc_reg, kr_next, kc_next;
  logic          kc_wrap, kr_wrap, ocol_wrap, orow_wrap;

  assign kc_wrap   = (kc_reg == K_MAX);
  assign kr_wrap   = (kr_reg == K_MAX);
  assign ocol_wrap = (ocol_reg == O_MAX);
  assign orow_wrap = (orow_reg == O_MAX);

  always_comb begin
    orow_next = orow_reg;
    ocol_next = ocol_reg;
    kr_next   = kr_reg;
    kc_next   = kc_reg;
    if (clear) begin
      orow_next = '0;
      ocol_next = '0;
      kr_next   = '0;
      kc_next   = '0;
    end else if (advance) begin
      kc_next = kc_wrap ? '0 : kc_reg + 1'b1;
      if (kc_wrap) kr_next = kr_wrap ? '0 : kr_reg + 1'b1;
      if (kc_wrap && kr_wrap) ocol_next = ocol_wrap ? '0 : ocol_reg + 1'b1;
      if (kc_wrap && kr_wrap && ocol_wrap) orow_next = orow_wrap ? '0 : orow_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orow_reg <= '0;
      ocol_reg <= '0;
      kr_reg   <= '0;
      kc_reg   <= '0;
    end else begin
      orow_reg <= orow_next;
      ocol_reg <= ocol_next;
      kr_reg   <= kr_next;
      kc_reg   <= kc_next;
    end
  end

  assign orow_idx = orow_next;
  assign ocol_idx = ocol_next;
  assign kr_idx   = kr_next;
  assign kc_idx   = kc_next;
  assign first    = (kr_next == '0) && (kc_next == '0);
  assign last_tap = (kr_next == K_MAX) && (kc_next == K_MAX);
  // last_beat refers to the beat currently held, not the look-ahead position.
  assign last_beat = kc_wrap && kr_wrap && ocol_wrap && orow_wrap;

endmodule

// File: rtl/conv_operand_sequencer.sv
// Snapshots the input matrix and filter on start, then streams one
// (input, filter) operand pair per beat with stride and zero padding.
module conv_operand_sequencer
  import conv_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IN_N   = 4,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int PAD    = 0,
  localparam int OUT_N = (IN_N + 2 * PAD - K) / STRIDE + 1,
  localparam int KW    = idx_w(K),
  localparam int OW    = idx_w(OUT_N),
  localparam int AIW   = idx_w(IN_N * IN_N),
  localparam int BIW   = idx_w(K * K)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [IN_N*IN_N*DATA_W-1:0]   a_flat,
  input  logic [K*K*DATA_W-1:0]         b_flat,
  conv_operand_sequencer_if.master      beat,
  output logic                          busy,
  output logic                          done
);

  seq_state_t state_reg, state_next;
  logic clear, advance, load, accept;

  logic [IN_N*IN_N*DATA_W-1:0] a_snap_reg, a_src;
  logic [K*K*DATA_W-1:0]       b_snap_reg, b_src;
  logic [DATA_W-1:0]           a_arr [IN_N*IN_N];
  logic [DATA_W-1:0]           b_arr [K*K];

  logic [OW-1:0] orow_idx, ocol_idx;
  logic [KW-1:0] kr_idx, kc_idx;
  logic          idx_first, idx_last_tap, last_beat;

  int              r_pos, c_pos;
  logic            in_bounds;
  logic [AIW-1:0]  a_idx;
  logic [BIW-1:0]  b_idx;
  logic [DATA_W-1:0] a_beat, b_beat;

  logic              out_valid_reg, win_first_reg, win_last_reg;
  logic [DATA_W-1:0] a_out_reg, b_out_reg;

  assign accept = out_valid_reg && beat.out_ready;

  conv_window_counter #(.K(K), .OUT_N(OUT_N)) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .advance   (advance),
    .orow_idx  (orow_idx),
    .ocol_idx  (ocol_idx),
    .kr_idx    (kr_idx),
    .kc_idx    (kc_idx),
    .first     (idx_first),
    .last_tap  (idx_last_tap),
    .last_beat (last_beat)
  );

  // Beat 0 is loaded on the same edge as the snapshot, so read the live inputs in IDLE.
  assign a_src = (state_reg == IDLE) ? a_flat : a_snap_reg;
  assign b_src = (state_reg == IDLE) ? b_flat : b_snap_reg;

  for (genvar gi = 0; gi < IN_N * IN_N; gi++) begin : g_a_unpack
    assign a_arr[gi] = a_src[gi*DATA_W +: DATA_W];
  end
  for (genvar gi = 0; gi < K * K; gi++) begin : g_b_unpack
    assign b_arr[gi] = b_src[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    r_pos     = int'(orow_idx) * STRIDE + int'(kr_idx) - PAD;
    c_pos     = int'(ocol_idx) * STRIDE + int'(kc_idx) - PAD;
    in_bounds = (r_pos >= 0) && (r_pos < IN_N) && (c_pos >= 0) && (c_pos < IN_N);
    a_idx     = '0;
    a_beat    = '0;
    if (in_bounds) begin
      a_idx  = AIW'(r_pos * IN_N + c_pos);
      a_beat = a_arr[a_idx];
    end
    b_idx  = BIW'(int'(kr_idx) * K + int'(kc_idx));
    b_beat = b_arr[b_idx];
  end

  always_comb begin
    state_next = state_reg;
    clear      = 1'b0;
    advance    = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: if (start) begin
        state_next = RUN;
        clear      = 1'b1;
        load       = 1'b1;
      end
      RUN: if (accept) begin
        advance = 1'b1;
        if (last_beat) state_next = DONE;
        else           load       = 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_snap_reg    <= '0;
      b_snap_reg    <= '0;
      out_valid_reg <= 1'b0;
      a_out_reg     <= '0;
      b_out_reg     <= '0;
      win_first_reg <= 1'b0;
      win_last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        a_snap_reg <= a_flat;
        b_snap_reg <= b_flat;
      end
      if (load) begin
        out_valid_reg <= 1'b1;
        a_out_reg     <= a_beat;
        b_out_reg     <= b_beat;
        win_first_reg <= idx_first;
        win_last_reg  <= idx_last_tap;
      end else if (accept) begin
        out_valid_reg <= 1'b0;
        a_out_reg     <= '0;
        b_out_reg     <= '0;
        win_first_reg <= 1'b0;
        win_last_reg  <= 1'b0;
      end
    end
  end

  assign beat.out_valid = out_valid_reg;
  assign beat.a_out     = a_out_reg;
  assign beat.b_out     = b_out_reg;
  assign beat.win_first = win_first_reg;
  assign beat.win_last  = win_last_reg;
  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == DONE);

endmodule
